slow_fpu_scheduler: RTL
=======================

Name: slow_fpu_scheduler

Overview:
- Sequences the multi-cycle (slow) FPU unit for instructions that decode flags with slow_fpu_dispatch: fdiv, fsqrt, and the slow conversions.
- Accepts one slow op at a time, issues it to the slow FPU, and holds the result in a single-entry buffer.
- Arbitrates the shared FPU register-file write port between the fast FPU pipe and the slow result.
- Reports RAW/WAW hazards on the pending destination so decode can stall.

Parameters:
- XLEN, 32, data width of FPU results.
- OP_W, 3, width of slow FPU op select.
- MAX_DEFER, 3, max consecutive cycles the slow result may lose write-port arbitration before it takes priority.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- dispatch_valid  in  1  decode presents a slow FPU op
- dispatch_ready  out  1  scheduler can accept an op this cycle
- dispatch_op  in  OP_W  slow op select
- dispatch_rd  in  5  FPU destination register
- flush  in  1  pipeline flush (branch mispredict/redirect)
- fpu_start  out  1  one-cycle start pulse to slow FPU
- fpu_op  out  OP_W  op select to slow FPU, stable from fpu_start until fpu_done
- fpu_done  in  1  slow FPU result valid (single-cycle pulse)
- fpu_result  in  XLEN  slow FPU result
- fast_wb_valid  in  1  fast FPU pipe requests the write port
- fast_wb_rd  in  5  fast FPU destination
- fast_wb_data  in  XLEN  fast FPU result
- fast_wb_stall  out  1  fast pipe must hold its writeback this cycle
- wb_en  out  1  FPU regfile write enable
- wb_rd  out  5  FPU regfile write address
- wb_data  out  XLEN  FPU regfile write data
- chk_rs1, chk_rs2, chk_rs3, chk_rd  in  5 each  decode-stage FPU register indices
- chk_rs1_v, chk_rs2_v, chk_rs3_v, chk_rd_v  in  1 each  index valid
- hazard  out  1  decode must stall

Behaviour:
- States: IDLE, ISSUE, BUSY, HOLD, DRAIN.
- Reset values: all registers cleared; state = IDLE; fpu_start = 0; wb_en = 0; fast_wb_stall = 0; hazard = 0; defer_cnt = 0.
- dispatch_ready = (state == IDLE). An op is accepted when dispatch_valid && dispatch_ready && !flush.
  - On accept: latch op and rd into pend_op and pend_rd, then go to ISSUE.
- ISSUE (1 cycle):
  - fpu_start = 1 and fpu_op = pend_op.
  - fpu_done is ignored in this state.
  - Next state is BUSY, or DRAIN if flush.
- BUSY:
  - On fpu_done, capture fpu_result into res_buf, clear defer_cnt, and go to HOLD.
  - On flush, go to DRAIN. If flush and fpu_done arrive together, the result is discarded and the next state is IDLE.
- DRAIN: wait for fpu_done, discard the result, go to IDLE. hazard = 0. dispatch_ready = 0.
- HOLD (write-port arbitration, combinational in the same cycle):
  - Slow wins if !fast_wb_valid || defer_cnt == MAX_DEFER.
    - wb_en = 1, wb_rd = pend_rd, wb_data = res_buf.
    - fast_wb_stall = fast_wb_valid.
    - Next state is IDLE.
  - Otherwise fast wins.
    - wb carries the fast_wb_* values; fast_wb_stall = 0.
    - defer_cnt increments (saturating); the scheduler stays in HOLD.
  - flush in HOLD discards the buffer and goes to IDLE with no slow write. Fast writeback still passes through.
- Outside HOLD:
  - wb_en = fast_wb_valid, with wb_rd and wb_data taken from the fast_wb_* inputs.
  - fast_wb_stall = 0.
- Minimum occupancy per op: accept → ISSUE → BUSY (≥1 cycle) → HOLD → IDLE. A new dispatch is accepted no earlier than the cycle after the slow write.
- hazard = (state is ISSUE, BUSY or HOLD) && any valid chk_* index equals pend_rd.
  - The chk_rd comparison covers WAW.
  - f0 is an ordinary register; there is no zero-register exclusion.
  - hazard drops in the same cycle as the slow write.
- Asserting rstn low mid-operation forces IDLE immediately. The slow FPU is reset by the same rstn.

Optional Feature:
- Macro SLOW_FPU_PERF_CNT_EN.
- Defined: adds 32-bit saturating counters, readable as outputs perf_busy_cycles, perf_defer_cycles and perf_hazard_cycles, all reset to 0.
  - perf_busy_cycles increments when state != IDLE.
  - perf_defer_cycles increments on each cycle the fast pipe wins in HOLD.
  - perf_hazard_cycles increments on each cycle hazard is high.
- Undefined: these ports and counters do not exist, and functional behaviour is identical.

Decomposition:
- Package fpu_sched_pkg holds:
  - the state enum sched_state_t;
  - the slow op enum slow_fpu_op_t (FDIV, FSQRT, FCVT_WS, FCVT_SW);
  - localparams for the widths.
- Sub-module fpu_wb_arbiter contains the HOLD-state write-port mux, fast_wb_stall, and the defer_cnt register.

Test Plan:
- Dispatch FDIV rd=5, fpu_done after 10 cycles, no fast traffic → fpu_start exactly 1 cycle after accept; wb_en with wb_rd=5 one cycle after done; dispatch_ready returns the next cycle.
- fast_wb_valid held high continuously while in HOLD, MAX_DEFER=3 → fast writes for 3 cycles, then the slow write with fast_wb_stall=1 on the 4th cycle.
- flush during BUSY, fpu_done 4 cycles later → no slow wb_en; dispatch_ready=0 until the cycle after fpu_done; hazard=0 during DRAIN.
- Pending rd=7: chk_rs2=7 with valid=1 → hazard=1; chk_rs2=7 with valid=0 → hazard=0; hazard clears in the write cycle.
- dispatch_valid and flush in the same IDLE cycle → op not accepted, fpu_start never pulses.
- rstn asserted while in BUSY → all outputs 0 and state IDLE asynchronously; a stray fpu_done after release is ignored.

Source files
------------

// File: rtl/fpu_sched_pkg.sv
// Shared types and default widths for the slow FPU scheduler and its write-port arbiter.
package fpu_sched_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int OP_W_DEF      = 3;
  localparam int MAX_DEFER_DEF = 3;
  localparam int REG_W         = 5;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    BUSY,
    HOLD,
    DRAIN
  } sched_state_t;

  typedef enum logic [OP_W_DEF-1:0] {
    FDIV,
    FSQRT,
    FCVT_WS,
    FCVT_SW
  } slow_fpu_op_t;

endpackage

// File: rtl/fpu_wb_arbiter.sv
// FPU regfile write-port mux: the buffered slow result competes with the fast pipe,
// and takes priority once it has lost MAX_DEFER consecutive rounds.
module fpu_wb_arbiter
  import fpu_sched_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int MAX_DEFER = MAX_DEFER_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             hold,
  input  logic             flush,
  input  logic             clear,
  input  logic             fast_wb_valid,
  input  logic [REG_W-1:0] fast_wb_rd,
  input  logic [XLEN-1:0]  fast_wb_data,
  input  logic [REG_W-1:0] slow_rd,
  input  logic [XLEN-1:0]  slow_data,
  output logic             wb_en,
  output logic [REG_W-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             fast_wb_stall,
  output logic             slow_write
);

  localparam int CNT_W = (MAX_DEFER < 1) ? 1 : $clog2(MAX_DEFER + 1);

  logic [CNT_W-1:0] defer_cnt;
  logic             at_limit;
  logic             contend;

  assign at_limit = (defer_cnt == CNT_W'(MAX_DEFER));
  // A flush in HOLD drops the slow result, so only the fast pipe can write.
  assign contend  = hold && !flush;

  // NOTE: every output gets a default before the override so no latch is inferred.
  always_comb begin
    slow_write    = contend && (!fast_wb_valid || at_limit);
    wb_en         = fast_wb_valid;
    wb_rd         = fast_wb_rd;
    wb_data       = fast_wb_data;
    fast_wb_stall = 1'b0;
    if (slow_write) begin
      wb_en         = 1'b1;
      wb_rd         = slow_rd;
      wb_data       = slow_data;
      fast_wb_stall = fast_wb_valid;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      defer_cnt <= '0;
    end else if (clear) begin
      defer_cnt <= '0;
    end else if (contend && fast_wb_valid && !at_limit) begin
      defer_cnt <= defer_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/slow_fpu_scheduler.sv
// Single-outstanding sequencer for the multi-cycle FPU with result buffer and RAW/WAW hazard
// reporting. Optional perf counters are enabled by defining SLOW_FPU_PERF_CNT_EN.
module slow_fpu_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int OP_W      = OP_W_DEF,
  parameter int MAX_DEFER = MAX_DEFER_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             dispatch_valid,
  output logic             dispatch_ready,
  input  logic [OP_W-1:0]  dispatch_op,
  input  logic [REG_W-1:0] dispatch_rd,
  input  logic             flush,
  output logic             fpu_start,
  output logic [OP_W-1:0]  fpu_op,
  input  logic             fpu_done,
  input  logic [XLEN-1:0]  fpu_result,
  input  logic             fast_wb_valid,
  input  logic [REG_W-1:0] fast_wb_rd,
  input  logic [XLEN-1:0]  fast_wb_data,
  output logic             fast_wb_stall,
  output logic             wb_en,
  output logic [REG_W-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_data,
  input  logic [REG_W-1:0] chk_rs1,
  input  logic [REG_W-1:0] chk_rs2,
  input  logic [REG_W-1:0] chk_rs3,
  input  logic [REG_W-1:0] chk_rd,
  input  logic             chk_rs1_v,
  input  logic             chk_rs2_v,
  input  logic             chk_rs3_v,
  input  logic             chk_rd_v,
`ifdef SLOW_FPU_PERF_CNT_EN
  output logic [31:0]      perf_busy_cycles,
  output logic [31:0]      perf_defer_cycles,
  output logic [31:0]      perf_hazard_cycles,
`endif
  output logic             hazard
);

  sched_state_t     state;
  logic [OP_W-1:0]  pend_op;
  logic [REG_W-1:0] pend_rd;
  logic [XLEN-1:0]  res_buf;
  logic             accept;
  logic             capture;
  logic             slow_write;
  logic             chk_hit;
  logic             active;

  assign dispatch_ready = (state == IDLE);
  assign accept         = dispatch_valid && dispatch_ready && !flush;
  assign capture        = (state == BUSY) && fpu_done && !flush;
  assign fpu_op         = pend_op;

  assign chk_hit = (chk_rs1_v && (chk_rs1 == pend_rd)) ||
                   (chk_rs2_v && (chk_rs2 == pend_rd)) ||
                   (chk_rs3_v && (chk_rs3 == pend_rd)) ||
                   (chk_rd_v  && (chk_rd  == pend_rd));
  assign active  = (state == ISSUE) || (state == BUSY) || (state == HOLD);
  // The pending destination is committed during the slow write, so decode may proceed.
  assign hazard  = active && chk_hit && !slow_write;

  fpu_wb_arbiter #(
    .XLEN      (XLEN),
    .MAX_DEFER (MAX_DEFER)
  ) u_wb_arb (
    .clk           (clk),
    .rstn          (rstn),
    .hold          (state == HOLD),
    .flush         (flush),
    .clear         (capture),
    .fast_wb_valid (fast_wb_valid),
    .fast_wb_rd    (fast_wb_rd),
    .fast_wb_data  (fast_wb_data),
    .slow_rd       (pend_rd),
    .slow_data     (res_buf),
    .wb_en         (wb_en),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .fast_wb_stall (fast_wb_stall),
    .slow_write    (slow_write)
  );

  // NOTE: the data registers are reset as well so outputs such as fpu_op never show X.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      pend_op   <= '0;
      pend_rd   <= '0;
      res_buf   <= '0;
      fpu_start <= 1'b0;
    end else begin
      fpu_start <= accept;
      unique case (state)
        IDLE: if (accept) begin
          pend_op <= dispatch_op;
          pend_rd <= dispatch_rd;
          state   <= ISSUE;
        end
        ISSUE: state <= flush ? DRAIN : BUSY;
        BUSY: begin
          if (fpu_done && flush)  state <= IDLE;
          else if (fpu_done) begin
            res_buf <= fpu_result;
            state   <= HOLD;
          end
          else if (flush)         state <= DRAIN;
        end
        HOLD:  if (flush || slow_write) state <= IDLE;
        DRAIN: if (fpu_done)            state <= IDLE;
        default:                        state <= IDLE;
      endcase
    end
  end

`ifdef SLOW_FPU_PERF_CNT_EN
  logic fast_won;
  assign fast_won = (state == HOLD) && !flush && fast_wb_valid && !slow_write;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_busy_cycles   <= '0;
      perf_defer_cycles  <= '0;
      perf_hazard_cycles <= '0;
    end else begin
      if ((state != IDLE) && (perf_busy_cycles != '1))  perf_busy_cycles   <= perf_busy_cycles + 32'd1;
      if (fast_won && (perf_defer_cycles != '1))        perf_defer_cycles  <= perf_defer_cycles + 32'd1;
      if (hazard && (perf_hazard_cycles != '1))         perf_hazard_cycles <= perf_hazard_cycles + 32'd1;
    end
  end
`endif

endmodule
